// File: rtl/cmd_dec.sv
// -----------------------------------------------------------------------------
// cmd_dec -- receive-side command decoder for the stimulator command link.
//
// Deserialises 16-bit command words (MSB first) from a strobed serial link and
// decodes them:
//   bias word      : {0, 7 reserved, BIAS_SEL, BIAS_AMP[6:0]}
//   amplitude word : {1, 2 reserved, ADDR[4:0], AMP[7:0]}
// Amplitude words land in a per-channel shadow bank. A TRG pulse copies the
// whole shadow bank into the active bank that drives the channel outputs.
//
// Optional feature macro: RESERVED_CHECK_EN
//   defined   -> words with any reserved bit set are rejected (CMD_ERR).
//   undefined -> reserved bits are ignored; CMD_LAST keeps the raw word.
//
// Parameter
//   CH_N         number of channels, 1..32 (the address field is 5 bits)
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous reset, active high
//   i_sframe     frame envelope, high for one 16-bit word
//   i_sstrobe    bit-valid strobe, one cycle per bit
//   i_sdata      serial data, sampled when i_sstrobe & i_sframe
//   i_trg        load pulse: active bank <= shadow bank
//   o_bias_sel   decoded bias select
//   o_bias_amp   decoded bias amplitude
//   o_amp_act    active amplitudes, channel k at [8k+7:8k]
//   o_cmd_last   last word accepted without error
//   o_cmd_valid  one-cycle pulse, word accepted
//   o_cmd_err    one-cycle pulse, word rejected
//   o_load_done  one-cycle pulse the cycle after a TRG
// -----------------------------------------------------------------------------
module cmd_dec #(
  parameter int CH_N = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sframe,
  input  logic              i_sstrobe,
  input  logic              i_sdata,
  input  logic              i_trg,
  output logic              o_bias_sel,
  output logic [6:0]        o_bias_amp,
  output logic [8*CH_N-1:0] o_amp_act,
  output logic [15:0]       o_cmd_last,
  output logic              o_cmd_valid,
  output logic              o_cmd_err,
  output logic              o_load_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DECODE,
    S_ERR
  } state_t;

  state_t              r_state;
  logic [15:0]         r_shift;
  logic [4:0]          r_cnt;        // sampled bits, 0..16
  logic                r_sframe_q;   // previous SFRAME sample
  logic                r_edge_pend;  // frame start seen while in DECODE/ERR
  logic [7:0]          r_shadow [CH_N];
  logic [8*CH_N-1:0]   r_amp_act;
  logic                r_bias_sel;
  logic [6:0]          r_bias_amp;
  logic [15:0]         r_cmd_last;
  logic                r_cmd_valid;
  logic                r_cmd_err;
  logic                r_load_done;

  logic                w_rise;
  logic                w_is_amp;
  logic [4:0]          w_addr;
  logic                w_addr_ok;
  logic                w_rsv_bad;
  logic                w_accept;
  logic                w_shadow_wr;

  assign w_rise    = i_sframe & ~r_sframe_q;
  assign w_is_amp  = r_shift[15];
  assign w_addr    = r_shift[12:8];
  assign w_addr_ok = ({27'd0, w_addr} < CH_N);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_rsv_bad = 1'b0;
`ifdef RESERVED_CHECK_EN
    if (w_is_amp) w_rsv_bad = |r_shift[14:13];
    else          w_rsv_bad = |r_shift[14:8];
`endif
  end

  // Bias words are always in range; amplitude words need a live channel.
  assign w_accept    = ~w_rsv_bad & (~w_is_amp | w_addr_ok);
  assign w_shadow_wr = (r_state == S_DECODE) & w_accept & w_is_amp;

  // Frame FSM, decode registers and shadow bank.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      // Reset as "high" so a frame already running at reset release is
      // ignored until SFRAME has been seen low.
      r_sframe_q  <= 1'b1;
      r_edge_pend <= 1'b0;
      r_bias_sel  <= 1'b0;
      r_bias_amp  <= '0;
      r_cmd_last  <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      // NOTE: the shadow bank is a register bank, not a RAM, and it must read
      // zero after reset so a TRG before any write loads zeros; it is
      // therefore reset element by element.
      for (int k = 0; k < CH_N; k++) r_shadow[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the pre-edge value regardless of statement order.
      r_sframe_q  <= i_sframe;
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;

      for (int k = 0; k < CH_N; k++) begin
        if (w_shadow_wr && (w_addr == 5'(k))) r_shadow[k] <= r_shift[7:0];
      end

      case (r_state)
        S_IDLE: begin
          r_edge_pend <= 1'b0;
          if (i_sframe && (w_rise || r_edge_pend)) begin
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (!i_sframe) begin
            r_state <= (r_cnt == 5'd16) ? S_DECODE : S_ERR;
          end else if (i_sstrobe) begin
            if (r_cnt == 5'd16) begin
              r_state <= S_ERR;          // 17th bit: overrun
            end else begin
              r_shift <= {r_shift[14:0], i_sdata};
              r_cnt   <= r_cnt + 5'd1;
            end
          end
        end

        S_DECODE: begin
          if (w_accept) begin
            r_cmd_last  <= r_shift;
            r_cmd_valid <= 1'b1;
            if (!w_is_amp) begin
              r_bias_sel <= r_shift[7];
              r_bias_amp <= r_shift[6:0];
            end
          end else begin
            r_cmd_err <= 1'b1;
          end
          // A new frame may start during this cycle; remember it for IDLE.
          r_edge_pend <= w_rise;
          r_state     <= S_IDLE;
        end

        S_ERR: begin
          r_cmd_err   <= 1'b1;
          r_shift     <= '0;
          r_edge_pend <= w_rise;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Trigger path, independent of the FSM. A shadow write in the same cycle
  // is not visible here yet, so the active bank gets the pre-write value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_amp_act   <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= i_trg;
      if (i_trg) begin
        for (int k = 0; k < CH_N; k++) r_amp_act[8*k +: 8] <= r_shadow[k];
      end
    end
  end

  assign o_bias_sel  = r_bias_sel;
  assign o_bias_amp  = r_bias_amp;
  assign o_amp_act   = r_amp_act;
  assign o_cmd_last  = r_cmd_last;
  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_err   = r_cmd_err;
  assign o_load_done = r_load_done;

endmodule

// File: tb/tb_cmd_dec.sv
// -----------------------------------------------------------------------------
// tb_cmd_dec -- scoreboard bench for cmd_dec.
//
// Two instances share the serial link: one with 32 channels, one with 8.
// The stimulus side keeps a word-level model of each decoder (bias registers,
// last word, shadow bank) and pushes the expected outcome of every frame and
// every TRG into per-instance queues, stamped with the cycle it must appear.
// A monitor on the falling edge pops and compares whenever a pulse appears,
// and checks every cycle that the held outputs match the last expected state.
// -----------------------------------------------------------------------------
module tb_cmd_dec;

  localparam int CH_A = 32;
  localparam int CH_B = 8;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic sframe  = 1'b0;
  logic sstrobe = 1'b0;
  logic sdata   = 1'b0;
  logic trg     = 1'b0;

  logic           sel_a, sel_b;
  logic [6:0]     amp_a, amp_b;
  logic [8*CH_A-1:0] act_a;
  logic [8*CH_B-1:0] act_b;
  logic [15:0]    last_a, last_b;
  logic           val_a, val_b, err_a, err_b, ld_a, ld_b;

  int unsigned cyc   = 0;
  logic        rst_q = 1'b1;
  int          n_checks = 0;
  int          n_fail   = 0;

  cmd_dec #(.CH_N(CH_A)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_sframe(sframe), .i_sstrobe(sstrobe),
    .i_sdata(sdata), .i_trg(trg),
    .o_bias_sel(sel_a), .o_bias_amp(amp_a), .o_amp_act(act_a),
    .o_cmd_last(last_a), .o_cmd_valid(val_a), .o_cmd_err(err_a),
    .o_load_done(ld_a)
  );

  cmd_dec #(.CH_N(CH_B)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_sframe(sframe), .i_sstrobe(sstrobe),
    .i_sdata(sdata), .i_trg(trg),
    .o_bias_sel(sel_b), .o_bias_amp(amp_b), .o_amp_act(act_b),
    .o_cmd_last(last_b), .o_cmd_valid(val_b), .o_cmd_err(err_b),
    .o_load_done(ld_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    logic        is_err;
    logic [15:0] last;
    logic        sel;
    logic [6:0]  amp;
    int unsigned cyc;
  } ev_t;

  typedef struct {
    logic [255:0] act;
    int unsigned  cyc;
  } ld_t;

  ev_t evq_a[$];
  ev_t evq_b[$];
  ld_t ldq_a[$];
  ld_t ldq_b[$];

  // Word-level reference model, one per instance.
  logic [7:0]  m_sh   [2][32];
  logic        m_sel  [2];
  logic [6:0]  m_amp  [2];
  logic [15:0] m_last [2];

  // Values the monitor expects the held outputs to show right now.
  logic [255:0] h_act  [2];
  logic [15:0]  h_last [2];
  logic         h_sel  [2];
  logic [6:0]   h_amp  [2];

  task automatic check(input string name, input logic [255:0] got,
                       input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h cycle=%0d", name, got, exp, cyc);
    end
  endtask

  function automatic int chn(input int d);
    return (d == 0) ? CH_A : CH_B;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Would a frame of nbits bits carrying word w be accepted?
  function automatic logic word_ok(input logic [15:0] w, input int nbits,
                                   input int ch);
    if (nbits != 16) return 1'b0;
`ifdef RESERVED_CHECK_EN
    if (w[15] ? (w[14:13] != 2'b00) : (w[14:8] != 7'd0)) return 1'b0;
`endif
    if (w[15] && (int'(w[12:8]) >= ch)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [255:0] bank_image(input int d);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < chn(d); k++) v[8*k +: 8] = m_sh[d][k];
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 32; k++) m_sh[d][k] = 8'h00;
      m_sel[d]  = 1'b0;
      m_amp[d]  = 7'd0;
      m_last[d] = 16'h0000;
    end
  endtask

  task automatic push_ev(input int d, input logic is_err, input int unsigned c);
    ev_t e;
    e.is_err = is_err;
    e.last   = m_last[d];
    e.sel    = m_sel[d];
    e.amp    = m_amp[d];
    e.cyc    = c;
    if (d == 0) evq_a.push_back(e);
    else        evq_b.push_back(e);
  endtask

  task automatic push_ld(input int d, input int unsigned c);
    ld_t e;
    e.act = bank_image(d);
    e.cyc = c;
    if (d == 0) ldq_a.push_back(e);
    else        ldq_b.push_back(e);
  endtask

  task automatic apply_word(input int d, input logic [15:0] w);
    if (w[15]) m_sh[d][w[12:8]] = w[7:0];
    else begin
      m_sel[d] = w[7];
      m_amp[d] = w[6:0];
    end
    m_last[d] = w;
  endtask

  // ------------------------------------------------------------------ monitor
  task automatic mon(input int d, input logic v, input logic e,
                     input logic [15:0] last, input logic sel,
                     input logic [6:0] amp, input logic [255:0] act,
                     input logic ld);
    ev_t x;
    ld_t y;
    int  n;
    if (rst_q) begin
      h_act[d]  = '0;
      h_last[d] = '0;
      h_sel[d]  = 1'b0;
      h_amp[d]  = '0;
      check("reset_pulses", 256'({v, e, ld}), 256'(0));
      check("reset_regs", 256'({sel, amp, last}), 256'(0));
      check("reset_amp_act", act, 256'(0));
      return;
    end

    n = (d == 0) ? evq_a.size() : evq_b.size();
    if (v || e) begin
      check("valid_err_exclusive", 256'(v & e), 256'(0));
      if (n == 0) begin
        check("unexpected_pulse", 256'({v, e}), 256'(0));
      end else begin
        x = (d == 0) ? evq_a.pop_front() : evq_b.pop_front();
        check("pulse_is_err", 256'(e), 256'(x.is_err));
        check("pulse_cycle", 256'(cyc), 256'(x.cyc));
        h_last[d] = x.last;
        h_sel[d]  = x.sel;
        h_amp[d]  = x.amp;
      end
    end else if (n > 0) begin
      x = (d == 0) ? evq_a[0] : evq_b[0];
      if (cyc > x.cyc) begin
        check("missing_pulse", 256'(cyc), 256'(x.cyc));
        x = (d == 0) ? evq_a.pop_front() : evq_b.pop_front();
        h_last[d] = x.last;
        h_sel[d]  = x.sel;
        h_amp[d]  = x.amp;
      end
    end

    n = (d == 0) ? ldq_a.size() : ldq_b.size();
    if (ld) begin
      if (n == 0) begin
        check("unexpected_load_done", 256'(ld), 256'(0));
      end else begin
        y = (d == 0) ? ldq_a.pop_front() : ldq_b.pop_front();
        check("load_done_cycle", 256'(cyc), 256'(y.cyc));
        h_act[d] = y.act;
      end
    end else if (n > 0) begin
      y = (d == 0) ? ldq_a[0] : ldq_b[0];
      if (cyc > y.cyc) begin
        check("missing_load_done", 256'(cyc), 256'(y.cyc));
        y = (d == 0) ? ldq_a.pop_front() : ldq_b.pop_front();
        h_act[d] = y.act;
      end
    end

    check("cmd_last", 256'(last), 256'(h_last[d]));
    check("bias_sel", 256'(sel), 256'(h_sel[d]));
    check("bias_amp", 256'(amp), 256'(h_amp[d]));
    check("amp_act", act, h_act[d]);
  endtask

  always @(negedge clk) begin
    mon(0, val_a, err_a, last_a, sel_a, amp_a, 256'(act_a), ld_a);
    mon(1, val_b, err_b, last_b, sel_b, amp_b, 256'(act_b), ld_b);
  end

  // ----------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send nbits bits of data, MSB first, with random strobe gaps. trg_dec puts
  // TRG in the cycle the decoder spends in its decode step.
  task automatic send_frame(input logic [16:0] data, input int nbits,
                            input logic trg_dec);
    int unsigned c_end;
    logic        ok;
    repeat (2 + $urandom_range(0, 2)) begin
      step(); sframe = 1'b0; sstrobe = rb(); sdata = rb(); trg = 1'b0;
    end
    step(); sframe = 1'b1; sstrobe = rb(); sdata = rb();
    for (int i = nbits - 1; i >= 0; i--) begin
      repeat ($urandom_range(0, 1)) begin
        step(); sstrobe = 1'b0; sdata = rb();
      end
      step(); sstrobe = 1'b1; sdata = data[i];
      if (nbits == 17 && i == 0) begin
        for (int d = 0; d < 2; d++) push_ev(d, 1'b1, cyc + 2);
      end
    end
    step(); sframe = 1'b0; sstrobe = 1'b0; sdata = rb();
    c_end = cyc;
    for (int d = 0; d < 2; d++) begin
      if (trg_dec) push_ld(d, c_end + 2);
      if (nbits != 17) begin
        ok = word_ok(data[15:0], nbits, chn(d));
        if (ok) apply_word(d, data[15:0]);
        push_ev(d, ~ok, c_end + 2);
      end
    end
    step(); trg = trg_dec;
    step(); trg = 1'b0;
  endtask

  task automatic pulse_trg(input int n);
    for (int i = 0; i < n; i++) begin
      step(); trg = 1'b1;
      for (int d = 0; d < 2; d++) push_ld(d, cyc + 1);
    end
    step(); trg = 1'b0;
  endtask

  task automatic wait_drain();
    int pend;
    for (int i = 0; i < 64; i++) begin
      pend = evq_a.size() + evq_b.size() + ldq_a.size() + ldq_b.size();
      if (pend == 0) break;
      step();
    end
    pend = evq_a.size() + evq_b.size() + ldq_a.size() + ldq_b.size();
    check("queues_drained", 256'(pend), 256'(0));
    evq_a.delete(); evq_b.delete(); ldq_a.delete(); ldq_b.delete();
  endtask

  initial begin
    logic [16:0] w17;
    logic [15:0] w;
    int          r;
    int          nb;

    model_reset();
    repeat (3) step();
    rst = 1'b0;

    // Bias word.
    send_frame(17'h000C5, 16, 1'b0);

    // Every channel address, then a load.
    for (int a = 0; a < 32; a++) begin
      w = {1'b1, 2'b00, 5'(a), 8'(a + 16)};
      send_frame({1'b0, w}, 16, 1'b0);
    end
    pulse_trg(1);

    // Short frame, overrun frame, then a good frame.
    send_frame(17'h0A5A5, 15, 1'b0);
    send_frame(17'h1F0F0, 17, 1'b0);
    send_frame(17'h00012, 16, 1'b0);

    // ADDR 10: in range for 32 channels, rejected for 8.
    send_frame(17'h08A33, 16, 1'b0);
    pulse_trg(1);

    // TRG coinciding with a shadow write.
    send_frame(17'h08311, 16, 1'b0);
    send_frame(17'h08322, 16, 1'b1);
    pulse_trg(1);

    // Reserved bit set in a bias word.
    send_frame(17'h04005, 16, 1'b0);

    // Reset in the middle of a frame with SFRAME held high.
    wait_drain();
    w = 16'h00FF;
    repeat (2) begin step(); sframe = 1'b0; sstrobe = 1'b0; end
    step(); sframe = 1'b1;
    for (int i = 15; i >= 8; i--) begin
      step(); sstrobe = 1'b1; sdata = w[i];
    end
    step(); rst = 1'b1; sstrobe = 1'b1; sdata = w[7];
    model_reset();
    step(); rst = 1'b0; sstrobe = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      step(); sstrobe = 1'b1; sdata = w[i];
    end
    step(); sframe = 1'b0; sstrobe = 1'b0;
    pulse_trg(1);
    send_frame(17'h00081, 16, 1'b0);

    // Back-to-back TRG.
    send_frame(17'h08577, 16, 1'b0);
    pulse_trg(3);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      w17 = 17'($urandom);
      if (r < 4) begin
        w17[15] = 1'b0;
        if ($urandom_range(0, 5) != 0) w17[14:8] = 7'd0;
      end else begin
        w17[15] = 1'b1;
        if ($urandom_range(0, 5) != 0) w17[14:13] = 2'b00;
      end
      nb = (r == 8) ? int'($urandom_range(0, 15)) : ((r == 9) ? 17 : 16);
      send_frame(w17, nb, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 7) == 0) pulse_trg(int'($urandom_range(1, 3)));
    end

    wait_drain();
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
